demux_1to2: RTL

Registered 1-to-2 stream demultiplexer: the inverse of the team's 2-to-1 mux. One valid/ready input stream is steered by a per-beat select bit to output port A or B, through a one-entry register slot per output. It also keeps per-output wrap-around beat counters. It sits in the basics library as the splitting counterpart to `mux_2to1` and defaults to the same 4-bit data width.

---
 rtl/demux_1to2_pkg.sv | 26 ++
 rtl/demux_out_slot.sv | 66 ++++++
 rtl/demux_1to2.sv | 64 ++++++
 3 files changed

// File: rtl/demux_1to2_pkg.sv
// rtl/demux_1to2_pkg.sv - shared basics constants and types for the 1-to-2 demux and its 2-to-1 mux counterpart
package demux_1to2_pkg;

    localparam logic MUX_SEL_A   = 1'b0;
    localparam logic MUX_SEL_B   = 1'b1;
    localparam logic DEMUX_SEL_A = 1'b0;
    localparam logic DEMUX_SEL_B = 1'b1;

    localparam int DEMUX_DEF_WIDTH = 4;
    localparam int DEMUX_DEF_CNT_W = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Bit 0 strobes slot A, bit 1 strobes slot B; nothing loads without an accepted beat.
    function automatic logic [1:0] demux_decode(input logic sel, input logic fire);
        logic [1:0] strobes;
        strobes    = 2'b00;
        strobes[0] = fire & (sel == DEMUX_SEL_A);
        strobes[1] = fire & (sel == DEMUX_SEL_B);
        return strobes;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// rtl/demux_out_slot.sv - one-entry output register slot with wrap-around delivered-beat counter
module demux_out_slot
    import demux_1to2_pkg::*;
#(
    parameter int WIDTH = DEMUX_DEF_WIDTH,
    parameter int CNT_W = DEMUX_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             can_accept
);

    slot_state_e      r_state;
    slot_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             w_drain;

    assign w_drain    = (r_state == SLOT_FULL) & out_ready;
    assign can_accept = (r_state == SLOT_EMPTY) | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A load in the same cycle as a drain keeps the slot full with the new beat.
    always_comb begin
        w_state_nxt = r_state;
        if (load) begin
            w_state_nxt = SLOT_FULL;
        end else if (w_drain) begin
            w_state_nxt = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_drain) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign valid = (r_state == SLOT_FULL);
    assign data  = r_data;
    assign count = r_count;

endmodule

// File: rtl/demux_1to2.sv
// rtl/demux_1to2.sv - registered 1-to-2 valid/ready stream demultiplexer with per-output beat counters
module demux_1to2
    import demux_1to2_pkg::*;
#(
    parameter int WIDTH = DEMUX_DEF_WIDTH,
    parameter int CNT_W = DEMUX_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic       w_a_can_accept;
    logic       w_b_can_accept;
    logic       w_in_fire;
    logic [1:0] w_load;

    // Only the selected slot gates the input, so a stalled B never blocks traffic to A.
    assign in_ready  = ~rst & ((in_sel == DEMUX_SEL_B) ? w_b_can_accept : w_a_can_accept);
    assign w_in_fire = in_valid & in_ready;
    assign w_load    = demux_decode(in_sel, w_in_fire);

    demux_out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_a (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load[0]),
        .load_data  (in_data),
        .out_ready  (a_ready),
        .valid      (a_valid),
        .data       (a_data),
        .count      (a_count),
        .can_accept (w_a_can_accept)
    );

    demux_out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_b (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load[1]),
        .load_data  (in_data),
        .out_ready  (b_ready),
        .valid      (b_valid),
        .data       (b_data),
        .count      (b_count),
        .can_accept (w_b_can_accept)
    );

endmodule
